// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared constants and types for the button conditioner
//
// Purpose : default timing constants, channel-count limit and the per-channel
//           status bundle passed from btn_channel up to button_conditioner.
// Ports   : none (package).

package button_pkg;

  localparam int N_BTN_MAX           = 16;
  localparam int DEBOUNCE_CYCLES_DEF = 250000;
  localparam int HOLD_CYCLES_DEF     = 50000000;

  // Registered outputs of one button channel.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic toggle;
    logic long_press;
  } btn_status_t;

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button channel: sync, debounce, edges, toggle, long press
//
// Purpose : conditions a single raw button input.
// Ports   : mclk     in   clock, all state on rising edge
//           reset_n  in   asynchronous active-low reset
//           btn      in   raw asynchronous button level, active-high
//           clr      in   synchronous clear of toggle/hold/pulse state
//           status   out  level, rise, fall, toggle, long_press (all registered)

module btn_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter bit TOGGLE_EN       = 1'b1
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic        btn,
  input  logic        clr,
  output btn_status_t status
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [DW-1:0] db_cnt;
  logic          level_q;
  logic          rise_q;
  logic          fall_q;
  logic          toggle_q;
  logic          long_press_q;
  logic [HW-1:0] hold_cnt;
  logic          flip;

  // The debounced level changes on the edge where the input has already
  // disagreed for DEBOUNCE_CYCLES-1 counted cycles and still disagrees.
  assign flip = (sync != level_q) && (db_cnt == DB_LAST);

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      meta         <= 1'b0;
      sync         <= 1'b0;
      db_cnt       <= '0;
      level_q      <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      toggle_q     <= 1'b0;
      long_press_q <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      meta <= btn;
      sync <= meta;

      // Debounce path ignores clr: level must keep tracking the button.
      if (sync == level_q) begin
        db_cnt <= '0;
      end else if (flip) begin
        db_cnt  <= '0;
        level_q <= ~level_q;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      if (clr) begin
        rise_q       <= 1'b0;
        fall_q       <= 1'b0;
        toggle_q     <= 1'b0;
        hold_cnt     <= '0;
        long_press_q <= 1'b0;
      end else begin
        // Pulses land together with the new level value.
        rise_q <= flip & ~level_q;
        fall_q <= flip &  level_q;

        // Toggle follows the registered rise, so a rise swallowed by clr
        // never reaches it and is not replayed later.
        toggle_q <= TOGGLE_EN ? (toggle_q ^ rise_q) : 1'b0;

        // Saturating hold counter: the pulse fires only on the step into
        // HOLD_CYCLES, giving one long_press per press.
        if (!level_q) begin
          hold_cnt     <= '0;
          long_press_q <= 1'b0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt     <= hold_cnt + 1'b1;
          long_press_q <= (hold_cnt == HOLD_LAST);
        end else begin
          long_press_q <= 1'b0;
        end
      end
    end
  end

  assign status.level      = level_q;
  assign status.rise       = rise_q;
  assign status.fall       = fall_q;
  assign status.toggle     = toggle_q;
  assign status.long_press = long_press_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - N independent debounced button channels
//
// Purpose : top level; instantiates one btn_channel per button.
// Ports   : mclk        in   clock
//           reset_n     in   asynchronous active-low reset
//           btn         in   raw button levels [N_BTN]
//           clr         in   synchronous clear, active-high
//           level       out  debounced levels
//           rise        out  one-cycle pulse on debounced 0->1
//           fall        out  one-cycle pulse on debounced 1->0
//           toggle      out  run/stop state (masked by TOGGLE_MASK)
//           long_press  out  one-cycle pulse when a hold reaches HOLD_CYCLES

module button_conditioner
  import button_pkg::*;
#(
  parameter int               N_BTN           = 4,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int               HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter logic [N_BTN-1:0] TOGGLE_MASK     = '1
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn,
  input  logic             clr,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] rise,
  output logic [N_BTN-1:0] fall,
  output logic [N_BTN-1:0] toggle,
  output logic [N_BTN-1:0] long_press
);

  if (N_BTN < 1 || N_BTN > N_BTN_MAX) begin : g_bad_n_btn
    $error("button_conditioner: N_BTN out of range");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_status_t st;

    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .TOGGLE_EN       (TOGGLE_MASK[i])
    ) u_ch (
      .mclk    (mclk),
      .reset_n (reset_n),
      .btn     (btn[i]),
      .clr     (clr),
      .status  (st)
    );

    assign level[i]      = st.level;
    assign rise[i]       = st.rise;
    assign fall[i]       = st.fall;
    assign toggle[i]     = st.toggle;
    assign long_press[i] = st.long_press;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner

module tb_button_conditioner;

  logic       mclk = 1'b0;
  logic       reset_n;
  logic       clr;
  logic [3:0] btn;
  logic [3:0] level, rise, fall, toggle, long_press;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int    cyc;
    string tag;
    int    ch;
    int    sig;   // 0 level, 1 rise, 2 fall, 3 toggle, 4 long_press
    logic  val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  button_conditioner #(
    .N_BTN           (4),
    .DEBOUNCE_CYCLES (8),
    .HOLD_CYCLES     (32),
    .TOGGLE_MASK     (4'b0101)
  ) dut (
    .mclk       (mclk),
    .reset_n    (reset_n),
    .btn        (btn),
    .clr        (clr),
    .level      (level),
    .rise       (rise),
    .fall       (fall),
    .toggle     (toggle),
    .long_press (long_press)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic get_sig(input int sig, input int ch);
    case (sig)
      0:       return level[ch];
      1:       return rise[ch];
      2:       return fall[ch];
      3:       return toggle[ch];
      default: return long_press[ch];
    endcase
  endfunction

  function automatic void push_exp(input int c, input string tag, input int ch,
                                   input int sig, input logic val);
    exp_t e;
    int   idx;
    e.cyc = c; e.tag = tag; e.ch = ch; e.sig = sig; e.val = val;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endfunction

  // One-cycle pulse: low before, high at p, low after.
  function automatic void push_pulse(input int p, input string tag, input int ch, input int sig);
    push_exp(p - 1, {tag, "_pre"},  ch, sig, 1'b0);
    push_exp(p,     tag,            ch, sig, 1'b1);
    push_exp(p + 1, {tag, "_post"}, ch, sig, 1'b0);
  endfunction

  // Scoreboard monitor: entry for cycle c is compared after posedge c.
  always @(negedge mclk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < cyc) check({mon_e.tag, "_late"}, 32'd1, 32'd0);
      else                 check(mon_e.tag, {31'd0, get_sig(mon_e.sig, mon_e.ch)}, {31'd0, mon_e.val});
    end
  end

  task automatic next_slot();
    @(negedge mclk);
    #1;
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge mclk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 3000) begin
      @(negedge mclk);
      n++;
    end
    #2;
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int r;
    reset_n = 1'b0;
    clr     = 1'b0;
    btn     = 4'b0000;
    repeat (3) @(negedge mclk);
    check("reset_outputs", {12'd0, level, rise, fall, toggle, long_press}, 32'd0);
    #1 reset_n = 1'b1;
    repeat (3) next_slot();

    // S1: steady press on ch0, latency, toggle, long press, release.
    next_slot(); k = cyc; btn[0] = 1'b1;
    push_exp(k + 9,  "s1_lvl0_pre", 0, 0, 1'b0);
    push_exp(k + 10, "s1_lvl0",     0, 0, 1'b1);
    push_pulse(k + 10, "s1_rise0", 0, 1);
    push_exp(k + 10, "s1_tog0_pre", 0, 3, 1'b0);
    push_exp(k + 11, "s1_tog0",     0, 3, 1'b1);
    push_pulse(k + 42, "s1_lp0", 0, 4);
    at_cyc(k + 45); r = cyc; btn[0] = 1'b0;
    push_exp(r + 9,  "s1_lvl0_relpre", 0, 0, 1'b1);
    push_exp(r + 10, "s1_lvl0_rel",    0, 0, 1'b0);
    push_pulse(r + 10, "s1_fall0", 0, 2);
    push_exp(r + 12, "s1_tog0_kept",   0, 3, 1'b1);
    drain();

    // S2: 7-cycle glitch on ch1 must be rejected.
    next_slot(); k = cyc; btn[1] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      push_exp(k + i, "s2_lvl1",  1, 0, 1'b0);
      push_exp(k + i, "s2_rise1", 1, 1, 1'b0);
      push_exp(k + i, "s2_tog1",  1, 3, 1'b0);
    end
    at_cyc(k + 7); btn[1] = 1'b0;
    drain();

    // S3: exactly 8-cycle pulse on ch3 is accepted; ch3 toggle masked.
    next_slot(); k = cyc; btn[3] = 1'b1;
    push_exp(k + 10, "s3_lvl3", 3, 0, 1'b1);
    push_pulse(k + 10, "s3_rise3", 3, 1);
    push_exp(k + 11, "s3_tog3", 3, 3, 1'b0);
    push_exp(k + 17, "s3_lvl3_hi", 3, 0, 1'b1);
    push_exp(k + 18, "s3_lvl3_lo", 3, 0, 1'b0);
    push_pulse(k + 18, "s3_fall3", 3, 2);
    at_cyc(k + 8); btn[3] = 1'b0;
    drain();

    // S4: two presses on ch1, toggle masked off.
    next_slot(); k = cyc; btn[1] = 1'b1;
    push_pulse(k + 10, "s4_rise1a", 1, 1);
    push_exp(k + 11, "s4_tog1a", 1, 3, 1'b0);
    push_pulse(k + 30, "s4_fall1a", 1, 2);
    push_pulse(k + 50, "s4_rise1b", 1, 1);
    push_exp(k + 51, "s4_tog1b", 1, 3, 1'b0);
    push_pulse(k + 70, "s4_fall1b", 1, 2);
    push_exp(k + 72, "s4_tog1_end", 1, 3, 1'b0);
    at_cyc(k + 20); btn[1] = 1'b0;
    at_cyc(k + 40); btn[1] = 1'b1;
    at_cyc(k + 60); btn[1] = 1'b0;
    drain();

    // S5: ch2 held 50 cycles: single long press, fall 10 cycles after release.
    next_slot(); k = cyc; btn[2] = 1'b1;
    push_pulse(k + 10, "s5_rise2", 2, 1);
    push_exp(k + 11, "s5_tog2", 2, 3, 1'b1);
    push_pulse(k + 42, "s5_lp2", 2, 4);
    for (int i = 44; i <= 62; i++) push_exp(k + i, "s5_lp2_once", 2, 4, 1'b0);
    push_pulse(k + 60, "s5_fall2", 2, 2);
    at_cyc(k + 50); btn[2] = 1'b0;
    drain();

    // S6: clr clears toggles; clr in the rise cycle suppresses rise/toggle;
    // a later clr restarts the hold count.
    next_slot(); clr = 1'b1;
    next_slot(); clr = 1'b0;
    check("s6_tog_clr", {28'd0, toggle}, 32'd0);
    next_slot(); k = cyc; btn[0] = 1'b1;
    push_exp(k + 10, "s6_lvl0",         0, 0, 1'b1);
    push_exp(k + 10, "s6_rise0_clr",    0, 1, 1'b0);
    push_exp(k + 11, "s6_rise0_after",  0, 1, 1'b0);
    push_exp(k + 10, "s6_tog0_a",       0, 3, 1'b0);
    push_exp(k + 11, "s6_tog0_b",       0, 3, 1'b0);
    push_exp(k + 12, "s6_tog0_c",       0, 3, 1'b0);
    push_exp(k + 42, "s6_lp0_early",    0, 4, 1'b0);
    push_pulse(k + 53, "s6_lp0", 0, 4);
    push_exp(k + 55, "s6_tog0_noreplay", 0, 3, 1'b0);
    push_exp(k + 55, "s6_lvl0_kept",    0, 0, 1'b1);
    push_pulse(k + 70, "s6_fall0", 0, 2);
    at_cyc(k + 9);  clr = 1'b1;
    at_cyc(k + 10); clr = 1'b0;
    at_cyc(k + 20); clr = 1'b1;
    at_cyc(k + 21); clr = 1'b0;
    at_cyc(k + 60); btn[0] = 1'b0;
    drain();

    // S7: simultaneous channels, then async reset mid-debounce on ch3.
    next_slot(); k = cyc; btn[0] = 1'b1; btn[2] = 1'b1;
    push_pulse(k + 10, "s7_rise0", 0, 1);
    push_pulse(k + 10, "s7_rise2", 2, 1);
    push_exp(k + 11, "s7_tog0", 0, 3, 1'b1);
    push_exp(k + 11, "s7_tog2", 2, 3, 1'b1);
    push_exp(k + 20, "s7_lvl0_pre_rst", 0, 0, 1'b1);
    at_cyc(k + 15); btn[3] = 1'b1;
    at_cyc(k + 20); reset_n = 1'b0;
    #1;
    check("s7_rst_async", {12'd0, level, rise, fall, toggle, long_press}, 32'd0);
    repeat (2) @(negedge mclk);
    check("s7_rst_hold", {12'd0, level, rise, fall, toggle, long_press}, 32'd0);
    #1 reset_n = 1'b1; r = cyc;
    push_exp(r + 9,  "s7_lvl3_pre", 3, 0, 1'b0);
    push_exp(r + 10, "s7_lvl3",     3, 0, 1'b1);
    push_pulse(r + 10, "s7_rise3", 3, 1);
    push_exp(r + 10, "s7_rise0_again", 0, 1, 1'b1);
    push_exp(r + 11, "s7_tog3_masked", 3, 3, 1'b0);
    push_exp(r + 11, "s7_tog2_again",  2, 3, 1'b1);
    drain();

    btn = 4'b0000;
    repeat (15) next_slot();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_BTN, default 4: number of independent button channels (1..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000: the number of consecutive cycles a synchronised input must differ from the debounced level before that level changes (>=1).
REQ-003 Parameter HOLD_CYCLES, default 50000000: the number of cycles a debounced level must stay high before the channel reports a long press (>DEBOUNCE_CYCLES).
REQ-004 Parameter TOGGLE_MASK, default all-ones [N_BTN]: bit i=1 gives channel i a run/stop toggle; bit i=0 holds channel i's toggle at 0.
REQ-005 mclk  in  1  the only clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 btn  in  N_BTN  raw asynchronous button levels, active-high.
REQ-008 clr  in  1  synchronous clear, already synchronous to mclk, active-high.
REQ-009 level  out  N_BTN  debounced button level.
REQ-010 rise  out  N_BTN  one-cycle pulse on each debounced 0->1 transition.
REQ-011 fall  out  N_BTN  one-cycle pulse on each debounced 1->0 transition.
REQ-012 toggle  out  N_BTN  run/stop state per channel.
REQ-013 long_press  out  N_BTN  one-cycle pulse when a hold reaches HOLD_CYCLES.

Function
REQ-014 Each channel SHALL pass btn[i] through a two-flop synchroniser; sync[i] is the second flop's output.
REQ-015 Debounce counter per channel, width $clog2(DEBOUNCE_CYCLES+1):
- The counter SHALL clear in any cycle where sync[i]==level[i].
- The counter SHALL increment in any cycle where sync[i]!=level[i].
REQ-016 level[i] SHALL invert, and the counter SHALL clear, on the edge where the counter equals DEBOUNCE_CYCLES-1 and sync[i] still differs.
- Latency from a steady btn change to level: 2+DEBOUNCE_CYCLES cycles.
- A glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no level change.
REQ-017 rise[i] and fall[i] SHALL be registered and SHALL assert in the same cycle level[i] takes its new value, for exactly one cycle.
- rise and fall SHALL never assert together.
REQ-018 If TOGGLE_MASK[i]=1, toggle[i] SHALL invert on the edge that registers rise[i]=1; otherwise toggle[i] SHALL stay 0.
REQ-019 Hold counter per channel, width $clog2(HOLD_CYCLES+1):
- The counter SHALL count cycles while level[i]=1 and SHALL saturate at HOLD_CYCLES.
- long_press[i] SHALL pulse once, in the cycle the counter reaches HOLD_CYCLES.
- The counter SHALL clear when level[i]=0.
- A press SHALL produce at most one long_press.
REQ-020 clr=1 actions, all in that cycle:
- Force toggle, hold counters, rise, fall and long_press to 0.
- Leave level and the debounce counters unaffected.
- clr SHALL win over a simultaneous rise-triggered toggle.
REQ-021 A rise suppressed by clr SHALL not be replayed.
- A button still held when clr deasserts SHALL start a fresh hold count and SHALL not toggle until its next rise.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be reported in the same cycle.

Reset
REQ-023 reset_n=0 SHALL asynchronously clear all synchroniser flops, counters, level, rise, fall, toggle and long_press to 0.
REQ-024 Reset deassertion needs no additional synchronisation inside this block.
- A button held through reset SHALL produce a rise 2+DEBOUNCE_CYCLES cycles after reset_n rises.

Structure
REQ-025 Package button_pkg SHALL hold:
- default constants DEBOUNCE_CYCLES_DEF and HOLD_CYCLES_DEF;
- the N_BTN_MAX=16 limit.
REQ-026 Per-channel logic SHALL live in one sub-module, btn_channel, parametrised by DEBOUNCE_CYCLES, HOLD_CYCLES and TOGGLE_EN.
- button_conditioner SHALL instantiate btn_channel N_BTN times via generate.

Verification (N_BTN=4, DEBOUNCE_CYCLES=8, HOLD_CYCLES=32, TOGGLE_MASK=4'b0101)
REQ-027 btn[0] 0->1 steady -> level[0]=1 and rise[0]=1 exactly 10 cycles later; toggle[0]=1 on the next cycle.
REQ-028 btn[1] high for 7 cycles then low -> level, rise and toggle for channel 1 remain 0 throughout.
REQ-029 btn[2] held 50 cycles -> one long_press[2] pulse 32 cycles after level[2] rises; on release, one fall[2] pulse 10 cycles after btn[2] falls.
REQ-030 btn[1] pressed twice -> rise[1] pulses twice and toggle[1] stays 0 (mask bit 0).
REQ-031 clr asserted in the rise[0] cycle -> rise[0] observed 0, toggle[0] unchanged at 0, level[0]=1 retained.
REQ-032 reset_n pulsed low mid-debounce with btn[3] high -> all outputs 0 immediately; rise[3] 10 cycles after reset_n rises.
